// File: rtl/mov_dest_scheduler.sv
// Round-robin arbiter and sequencer for the single mov destination path.
// Each granted mov holds mov_en and its destination for MOV_CYCLES cycles; a pim_mode drop aborts it.
module mov_dest_scheduler #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DEST_W     = 4,
    parameter int unsigned MOV_CYCLES = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pim_mode,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DEST_W-1:0]   req_dest,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        mov_en,
    output logic [DEST_W-1:0]           mov_dest_bin,
    output logic [2**DEST_W-1:0]        mov_dest_onehot,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(NUM_REQ)-1:0]  done_id,
    output logic                        abort,
    output logic [CNT_W-1:0]            mov_count
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);
    localparam int unsigned OH_W = 2**DEST_W;
    localparam int unsigned CC_W = (MOV_CYCLES > 1) ? $clog2(MOV_CYCLES) : 1;
    localparam logic [CC_W-1:0] CntLoad = CC_W'(MOV_CYCLES - 1);

    typedef enum logic {StIdle, StDrive} state_e;

    state_e              state_q, state_d;
    logic [CC_W-1:0]     cnt_q, cnt_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                mov_en_q, mov_en_d;
    logic [DEST_W-1:0]   dest_q, dest_d;
    logic [OH_W-1:0]     onehot_q, onehot_d;
    logic                done_q, done_d;
    logic                abort_q, abort_d;
    logic [ID_W-1:0]     done_id_q, done_id_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                win_found;
    logic [ID_W-1:0]     win_idx;
    logic [ID_W-1:0]     cand;
    logic [DEST_W-1:0]   win_dest;
    logic                grant;
    logic                complete;

    // Search starts one past the last grant so every valid requester is served in turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(last_q) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign grant     = (state_q == StIdle) && pim_mode && win_found;
    assign req_ready = grant ? (NUM_REQ'(1) << win_idx) : '0;
    assign win_dest  = req_dest[32'(win_idx) * DEST_W +: DEST_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        id_d      = id_q;
        mov_en_d  = mov_en_q;
        dest_d    = dest_q;
        onehot_d  = onehot_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        done_id_d = done_id_q;
        count_d   = count_q;
        complete  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d           = StDrive;
                    cnt_d             = CntLoad;
                    last_d            = win_idx;
                    id_d              = win_idx;
                    mov_en_d          = 1'b1;
                    dest_d            = win_dest;
                    onehot_d          = '0;
                    onehot_d[win_dest] = 1'b1;
                    if (CntLoad == '0) begin
                        complete  = 1'b1;
                        done_id_d = win_idx;
                    end
                end
            end
            StDrive: begin
                if (cnt_q == '0) begin
                    state_d  = StIdle;
                    mov_en_d = 1'b0;
                    dest_d   = '0;
                    onehot_d = '0;
                end else if (!pim_mode) begin
                    // Checked before completion so a drop on the final edge still aborts.
                    state_d   = StIdle;
                    mov_en_d  = 1'b0;
                    dest_d    = '0;
                    onehot_d  = '0;
                    abort_d   = 1'b1;
                    done_id_d = id_q;
                end else begin
                    cnt_d = cnt_q - CC_W'(1);
                    if (cnt_q == CC_W'(1)) begin
                        complete  = 1'b1;
                        done_id_d = id_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (complete) begin
            done_d  = 1'b1;
            count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            last_q    <= ID_W'(NUM_REQ - 1);
            id_q      <= '0;
            mov_en_q  <= 1'b0;
            dest_q    <= '0;
            onehot_q  <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            done_id_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            id_q      <= id_d;
            mov_en_q  <= mov_en_d;
            dest_q    <= dest_d;
            onehot_q  <= onehot_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            done_id_q <= done_id_d;
            count_q   <= count_d;
        end
    end

    assign mov_en          = mov_en_q;
    assign mov_dest_bin    = dest_q;
    assign mov_dest_onehot = onehot_q;
    assign busy            = (state_q != StIdle);
    assign done            = done_q;
    assign done_id         = done_id_q;
    assign abort           = abort_q;
    assign mov_count       = count_q;

endmodule

// File: tb/tb_mov_dest_scheduler.sv
// Scoreboard bench for mov_dest_scheduler: grants push expected movs, a negedge monitor
// checks the active destination and pops on every done/abort pulse.
module tb_mov_dest_scheduler;

    localparam int NR = 4;
    localparam int DW = 4;
    localparam int MC = 3;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              pim_mode;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_dest;
    logic [NR-1:0]     req_ready;
    logic              mov_en;
    logic [DW-1:0]     mov_dest_bin;
    logic [15:0]       mov_dest_onehot;
    logic              busy;
    logic              done;
    logic [1:0]        done_id;
    logic              abort;
    logic [CW-1:0]     mov_count;

    mov_dest_scheduler #(
        .NUM_REQ    (NR),
        .DEST_W     (DW),
        .MOV_CYCLES (MC),
        .CNT_W      (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pim_mode        (pim_mode),
        .req_valid       (req_valid),
        .req_dest        (req_dest),
        .req_ready       (req_ready),
        .mov_en          (mov_en),
        .mov_dest_bin    (mov_dest_bin),
        .mov_dest_onehot (mov_dest_onehot),
        .busy            (busy),
        .done            (done),
        .done_id         (done_id),
        .abort           (abort),
        .mov_count       (mov_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_abort;
        int          id;
        logic [3:0]  dest;
        logic [15:0] onehot;
        logic [1:0]  count;
        int          en_cycles;
    } rec_t;

    rec_t       sb[$];
    rec_t       r_mon;
    logic [1:0] exp_count;
    int         en_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            en_cnt = 0;
        end else begin
            if (mov_en) begin
                en_cnt++;
                if (sb.size() == 0) begin
                    check("mov_en_unexpected", 32'(mov_en), 32'd0);
                end else begin
                    check("dest_bin", 32'(mov_dest_bin), 32'(sb[0].dest));
                    check("dest_onehot", 32'(mov_dest_onehot), 32'(sb[0].onehot));
                    check("busy_drive", 32'(busy), 32'd1);
                end
            end else begin
                check("onehot_idle", 32'(mov_dest_onehot), 32'd0);
            end
            if (done || abort) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 32'({done, abort}), 32'd0);
                end else begin
                    r_mon = sb.pop_front();
                    check("abort_flag", 32'(abort), 32'(r_mon.is_abort));
                    check("done_flag", 32'(done), 32'(!r_mon.is_abort));
                    check("done_id", 32'(done_id), 32'(r_mon.id));
                    check("mov_count", 32'(mov_count), 32'(r_mon.count));
                    check("en_cycles", 32'(en_cnt), 32'(r_mon.en_cycles));
                    if (abort) check("mov_en_after_abort", 32'(mov_en), 32'd0);
                end
                en_cnt = 0;
            end
        end
    end

    // Waits for a grant, checks it, and queues the expected mov outcome.
    task automatic grant(input int exp_id, input logic [3:0] dest, input logic [15:0] oh,
                         input logic [3:0] exp_rdy, input bit is_ab, output int hs);
        bit found = 1'b0;
        rec_t r;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (|req_ready) found = 1'b1;
        end
        hs = cyc;
        if (!found) begin
            check("grant_timeout", 32'(req_ready), 32'(exp_rdy));
        end else begin
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("busy_at_grant", 32'(busy), 32'd0);
            if (!is_ab) exp_count = (exp_count == 2'd3) ? 2'd3 : exp_count + 2'd1;
            r.is_abort  = is_ab;
            r.id        = exp_id;
            r.dest      = dest;
            r.onehot    = oh;
            r.count     = exp_count;
            r.en_cycles = is_ab ? 2 : MC;
            sb.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) break;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    int hs, hs_prev, t_raise;

    initial begin
        rst       = 1'b1;
        pim_mode  = 1'b0;
        req_valid = '0;
        req_dest  = '0;
        exp_count = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mov_en", 32'(mov_en), 32'd0);
        check("rst_onehot", 32'(mov_dest_onehot), 32'd0);
        check("rst_bin", 32'(mov_dest_bin), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        check("rst_count", 32'(mov_count), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);

        // Single mov, dest 5
        @(posedge clk);
        #1;
        pim_mode  = 1'b1;
        req_valid = 4'b0001;
        req_dest  = 16'h0005;
        grant(0, 4'd5, 16'h0020, 4'b0001, 1'b0, hs);
        req_valid = '0;
        wait_idle();

        // Round robin with all four valid; count saturates at 3
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        exp_count = '0;
        req_dest  = {4'd4, 4'd3, 4'd2, 4'd1};
        req_valid = 4'b1111;
        grant(0, 4'd1, 16'h0002, 4'b0001, 1'b0, hs_prev);
        grant(1, 4'd2, 16'h0004, 4'b0010, 1'b0, hs);
        check("hs_gap_1", 32'(hs - hs_prev), 32'd4);
        hs_prev = hs;
        grant(2, 4'd3, 16'h0008, 4'b0100, 1'b0, hs);
        check("hs_gap_2", 32'(hs - hs_prev), 32'd4);
        hs_prev = hs;
        grant(3, 4'd4, 16'h0010, 4'b1000, 1'b0, hs);
        check("hs_gap_3", 32'(hs - hs_prev), 32'd4);
        hs_prev = hs;
        grant(0, 4'd1, 16'h0002, 4'b0001, 1'b0, hs);
        check("hs_gap_4", 32'(hs - hs_prev), 32'd4);
        req_valid = '0;
        wait_idle();

        // Mode gating
        rst      = 1'b1;
        pim_mode = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        exp_count = '0;
        req_valid = 4'b1111;
        repeat (10) begin
            @(negedge clk);
            check("gated_ready", 32'(req_ready), 32'd0);
            check("gated_busy", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;
        pim_mode = 1'b1;
        t_raise  = cyc;
        grant(0, 4'd1, 16'h0002, 4'b0001, 1'b0, hs);
        check("grant_same_cycle", 32'(hs - t_raise), 32'd0);

        // Abort on the second drive cycle of requester 2, dest 15
        req_valid       = 4'b0100;
        req_dest[11:8]  = 4'd15;
        grant(2, 4'd15, 16'h8000, 4'b0100, 1'b1, hs);
        req_valid = '0;
        @(posedge clk);
        #1;
        pim_mode = 1'b0;
        @(posedge clk);
        #1;
        pim_mode  = 1'b1;
        req_valid = 4'b1111;
        grant(3, 4'd4, 16'h0010, 4'b1000, 1'b0, hs);
        req_valid = '0;

        // Reset during the drive of requester 3
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_count = '0;
        @(negedge clk);
        check("midrst_mov_en", 32'(mov_en), 32'd0);
        check("midrst_onehot", 32'(mov_dest_onehot), 32'd0);
        check("midrst_bin", 32'(mov_dest_bin), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_abort", 32'(abort), 32'd0);
        check("midrst_count", 32'(mov_count), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 4'b1111;
        grant(0, 4'd1, 16'h0002, 4'b0001, 1'b0, hs);
        req_valid = '0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
